// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes and immediate formats.
// The execute stage imports the same ALU codes.
package rv_decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  function automatic logic signed [31:0] imm_gen(imm_fmt_e fmt, logic [31:0] ins);
    logic signed [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // funct7[5] selects SUB only for register-register ops; SRA applies to both forms.
  function automatic alu_op_e alu_from_funct(logic [2:0] f3, logic alt, logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch/hazard/write-back inputs and the execute-facing outputs.
interface decode_if #(parameter int XLEN = 32);
  logic [31:0]     instr_i;
  logic            instr_valid_i;
  logic            stall_i;
  logic            flush_i;
  logic            wb_en_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            valid_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic [XLEN-1:0] imm_o;
  logic [3:0]      alu_op_o;
  logic            alu_src_o;
  logic            reg_write_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            branch_o;
  logic            jump_o;
  logic            illegal_o;

  modport master (
    output instr_i, instr_valid_i, stall_i, flush_i, wb_en_i, wb_rd_i, wb_data_i,
    input  valid_o, rs1_o, rs2_o, rd_o, rs1_data_o, rs2_data_o, imm_o, alu_op_o,
           alu_src_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o
  );

  modport slave (
    input  instr_i, instr_valid_i, stall_i, flush_i, wb_en_i, wb_rd_i, wb_data_i,
    output valid_o, rs1_o, rs2_o, rd_o, rs1_data_o, rs2_data_o, imm_o, alu_op_o,
           alu_src_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// Register file: async clear, one write port, two combinational read ports with
// write-back bypass; entry 0 always reads zero.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(logic [AW-1:0] ra);
    logic [XLEN-1:0] d;
    if (ra == '0)                  d = '0;
    else if (we && waddr == ra)    d = wdata;
    else                           d = regs[ra];
    return d;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode and operand read (p0) feeding a
// stallable, flushable pipeline register (p1) towards execute.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic      clk1,
  input  logic      rst,
  decode_if.slave   bus
);

  logic [6:0]             opcode_p0;
  logic [2:0]             funct3_p0;
  logic                   alt_p0;
  logic [4:0]             rs1_p0, rs2_p0, rd_p0;
  imm_fmt_e               fmt_p0;
  ctrl_t                  ctrl_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [XLEN-1:0]        rs1_data_p0, rs2_data_p0;

  assign opcode_p0 = bus.instr_i[6:0];
  assign rd_p0     = bus.instr_i[11:7];
  assign funct3_p0 = bus.instr_i[14:12];
  assign rs1_p0    = bus.instr_i[19:15];
  assign rs2_p0    = bus.instr_i[24:20];
  assign alt_p0    = bus.instr_i[30];

  always_comb begin
    ctrl_p0        = '0;
    ctrl_p0.alu_op = ALU_ADD;
    fmt_p0         = IMM_NONE;
    case (opcode_p0)
      OP_R:      begin ctrl_p0.reg_write = 1'b1; ctrl_p0.alu_op = alu_from_funct(funct3_p0, alt_p0, 1'b1); end
      OP_IMM:    begin fmt_p0 = IMM_I; ctrl_p0.alu_src = 1'b1; ctrl_p0.reg_write = 1'b1;
                       ctrl_p0.alu_op = alu_from_funct(funct3_p0, alt_p0, 1'b0); end
      OP_LOAD:   begin fmt_p0 = IMM_I; ctrl_p0.alu_src = 1'b1; ctrl_p0.reg_write = 1'b1; ctrl_p0.mem_read = 1'b1; end
      OP_STORE:  begin fmt_p0 = IMM_S; ctrl_p0.alu_src = 1'b1; ctrl_p0.mem_write = 1'b1; end
      OP_BRANCH: begin fmt_p0 = IMM_B; ctrl_p0.branch = 1'b1; ctrl_p0.alu_op = ALU_SUB; end
      OP_JAL:    begin fmt_p0 = IMM_J; ctrl_p0.alu_src = 1'b1; ctrl_p0.reg_write = 1'b1; ctrl_p0.jump = 1'b1; end
      OP_JALR:   begin fmt_p0 = IMM_I; ctrl_p0.alu_src = 1'b1; ctrl_p0.reg_write = 1'b1; ctrl_p0.jump = 1'b1; end
      OP_LUI:    begin fmt_p0 = IMM_U; ctrl_p0.alu_src = 1'b1; ctrl_p0.reg_write = 1'b1; ctrl_p0.alu_op = ALU_PASSB; end
      OP_AUIPC:  begin fmt_p0 = IMM_U; ctrl_p0.alu_src = 1'b1; ctrl_p0.reg_write = 1'b1; end
      default:   ctrl_p0.illegal = 1'b1;
    endcase
    // A bubble must not cause side effects downstream.
    if (!bus.instr_valid_i) begin
      ctrl_p0.reg_write = 1'b0;
      ctrl_p0.mem_read  = 1'b0;
      ctrl_p0.mem_write = 1'b0;
      ctrl_p0.branch    = 1'b0;
      ctrl_p0.jump      = 1'b0;
      ctrl_p0.illegal   = 1'b0;
    end
  end

  assign imm_p0 = XLEN'(imm_gen(fmt_p0, bus.instr_i));

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
    .clk1   (clk1),
    .rst    (rst),
    .we     (bus.wb_en_i),
    .waddr  (bus.wb_rd_i),
    .wdata  (bus.wb_data_i),
    .raddr1 (rs1_p0),
    .raddr2 (rs2_p0),
    .rdata1 (rs1_data_p0),
    .rdata2 (rs2_data_p0)
  );

  // ---- p0 -> p1 pipeline register ----
  logic            vld_p1;
  ctrl_t           ctrl_p1;
  logic [4:0]      rs1_p1, rs2_p1, rd_p1;
  logic [XLEN-1:0] rs1_data_p1, rs2_data_p1, imm_p1;
  logic            hit1_p1, hit2_p1;

  // A stalled instruction keeps its operands fresh against later write-backs.
  assign hit1_p1 = bus.wb_en_i && (bus.wb_rd_i == rs1_p1) && (rs1_p1 != 5'd0);
  assign hit2_p1 = bus.wb_en_i && (bus.wb_rd_i == rs2_p1) && (rs2_p1 != 5'd0);

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
    end else if (bus.flush_i) begin
      vld_p1            <= 1'b0;
      ctrl_p1.reg_write <= 1'b0;
      ctrl_p1.mem_read  <= 1'b0;
      ctrl_p1.mem_write <= 1'b0;
      ctrl_p1.branch    <= 1'b0;
      ctrl_p1.jump      <= 1'b0;
      ctrl_p1.illegal   <= 1'b0;
    end else if (bus.stall_i) begin
      if (hit1_p1) rs1_data_p1 <= bus.wb_data_i;
      if (hit2_p1) rs2_data_p1 <= bus.wb_data_i;
    end else begin
      vld_p1      <= bus.instr_valid_i;
      ctrl_p1     <= ctrl_p0;
      rs1_p1      <= rs1_p0;
      rs2_p1      <= rs2_p0;
      rd_p1       <= rd_p0;
      rs1_data_p1 <= rs1_data_p0;
      rs2_data_p1 <= rs2_data_p0;
      imm_p1      <= imm_p0;
    end
  end

  assign bus.valid_o     = vld_p1;
  assign bus.rs1_o       = rs1_p1;
  assign bus.rs2_o       = rs2_p1;
  assign bus.rd_o        = rd_p1;
  assign bus.rs1_data_o  = rs1_data_p1;
  assign bus.rs2_data_o  = rs2_data_p1;
  assign bus.imm_o       = imm_p1;
  assign bus.alu_op_o    = ctrl_p1.alu_op;
  assign bus.alu_src_o   = ctrl_p1.alu_src;
  assign bus.reg_write_o = ctrl_p1.reg_write;
  assign bus.mem_read_o  = ctrl_p1.mem_read;
  assign bus.mem_write_o = ctrl_p1.mem_write;
  assign bus.branch_o    = ctrl_p1.branch;
  assign bus.jump_o      = ctrl_p1.jump;
  assign bus.illegal_o   = ctrl_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_decode_stage;

  logic clk1 = 1'b0;
  logic rst  = 1'b0;
  always #5 clk1 = ~clk1;

  decode_if #(.XLEN(32)) bus ();

  decode_stage dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct {
    bit        v;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] d1, d2, imm;
    bit [3:0]  op;
    bit        src, rw, mr, mw, br, jp, ill;
  } exp_t;

  exp_t      e;
  bit [31:0] mregs [32];
  int        n_checks = 0;
  int        n_errs   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_decode(input bit [31:0] w, input bit vin);
    exp_t r;
    int   arith [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    bit [2:0] f3;
    bit   alt;
    r = '{default: '0};
    f3  = w[14:12];
    alt = w[30];
    r.v = vin; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
    case (w[6:0])
      7'h33: begin r.op = 4'(arith[f3]); if (f3 == 0 && alt) r.op = 1; if (f3 == 5 && alt) r.op = 7; r.rw = 1; end
      7'h13: begin r.op = 4'(arith[f3]); if (f3 == 5 && alt) r.op = 7; r.src = 1; r.rw = 1;
                   r.imm = 32'(int'($signed(w[31:20]))); end
      7'h03: begin r.src = 1; r.rw = 1; r.mr = 1; r.imm = 32'(int'($signed(w[31:20]))); end
      7'h23: begin r.src = 1; r.mw = 1; r.imm = 32'(int'($signed({w[31:25], w[11:7]}))); end
      7'h63: begin r.op = 1; r.br = 1;
                   r.imm = (w[31] ? 32'hFFFFF000 : 0) + w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2; end
      7'h6F: begin r.src = 1; r.rw = 1; r.jp = 1;
                   r.imm = (w[31] ? 32'hFFF00000 : 0) + w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2; end
      7'h67: begin r.src = 1; r.rw = 1; r.jp = 1; r.imm = 32'(int'($signed(w[31:20]))); end
      7'h37: begin r.op = 10; r.src = 1; r.rw = 1; r.imm = {w[31:12], 12'h000}; end
      7'h17: begin r.src = 1; r.rw = 1; r.imm = {w[31:12], 12'h000}; end
      default: r.ill = 1;
    endcase
    if (!vin) begin r.rw = 0; r.mr = 0; r.mw = 0; r.br = 0; r.jp = 0; r.ill = 0; end
    return r;
  endfunction

  function automatic bit [31:0] model_read(input bit [4:0] r);
    if (r == 0) return 32'h0;
    if (bus.wb_en_i && bus.wb_rd_i == r) return bus.wb_data_i;
    return mregs[r];
  endfunction

  task automatic compare_all(input bit full);
    check_val("valid", 32'(bus.valid_o), 32'(e.v));
    check_val("reg_write", 32'(bus.reg_write_o), 32'(e.rw));
    check_val("mem_read", 32'(bus.mem_read_o), 32'(e.mr));
    check_val("mem_write", 32'(bus.mem_write_o), 32'(e.mw));
    check_val("branch", 32'(bus.branch_o), 32'(e.br));
    check_val("jump", 32'(bus.jump_o), 32'(e.jp));
    check_val("illegal", 32'(bus.illegal_o), 32'(e.ill));
    if (full || e.v) begin
      check_val("rs1", 32'(bus.rs1_o), 32'(e.rs1));
      check_val("rs2", 32'(bus.rs2_o), 32'(e.rs2));
      check_val("rd", 32'(bus.rd_o), 32'(e.rd));
      check_val("rs1_data", bus.rs1_data_o, e.d1);
      check_val("rs2_data", bus.rs2_data_o, e.d2);
      check_val("imm", bus.imm_o, e.imm);
      check_val("alu_op", 32'(bus.alu_op_o), 32'(e.op));
      check_val("alu_src", 32'(bus.alu_src_o), 32'(e.src));
    end
  endtask

  task automatic model_clear();
    e = '{default: '0};
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
  endtask

  // One clock: predict from the inputs present at the edge, then compare just after it.
  task automatic tick();
    exp_t n;
    n = e;
    if (rst) begin
      if (bus.flush_i) begin
        n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.br = 0; n.jp = 0; n.ill = 0;
      end else if (bus.stall_i) begin
        if (bus.wb_en_i && bus.wb_rd_i != 0 && bus.wb_rd_i == e.rs1) n.d1 = bus.wb_data_i;
        if (bus.wb_en_i && bus.wb_rd_i != 0 && bus.wb_rd_i == e.rs2) n.d2 = bus.wb_data_i;
      end else begin
        n = model_decode(bus.instr_i, bus.instr_valid_i);
        n.d1 = model_read(n.rs1);
        n.d2 = model_read(n.rs2);
      end
      if (bus.wb_en_i && bus.wb_rd_i != 0) mregs[bus.wb_rd_i] = bus.wb_data_i;
    end
    @(posedge clk1);
    e = n;
    #1;
    compare_all(1'b0);
  endtask

  // Asynchronous reset assertion away from any clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_clear();
    compare_all(1'b1);
    @(posedge clk1);
    #1;
    compare_all(1'b1);
    rst = 1'b1;
  endtask

  task automatic drive(input bit [31:0] w, input bit vin, input bit stl, input bit fl,
                       input bit we, input bit [4:0] wr, input bit [31:0] wd);
    bus.instr_i = w; bus.instr_valid_i = vin; bus.stall_i = stl; bus.flush_i = fl;
    bus.wb_en_i = we; bus.wb_rd_i = wr; bus.wb_data_i = wd;
  endtask

  function automatic bit [31:0] rand_instr();
    bit [6:0]  opl [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    bit [31:0] w;
    int        k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = opl[k];
    if ($urandom_range(0, 3) != 0) begin
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
    end
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    model_clear();
    drive(32'h0, 0, 0, 0, 0, 5'd0, 32'h0);
    #1;
    compare_all(1'b1);
    @(posedge clk1); #1;
    compare_all(1'b1);
    rst = 1'b1;

    // ADDI x1,x0,5
    drive(32'h00500093, 1, 0, 0, 0, 5'd0, 32'h0);
    tick();
    check_val("t1_valid", 32'(bus.valid_o), 32'd1);
    check_val("t1_rd", 32'(bus.rd_o), 32'd1);
    check_val("t1_imm", bus.imm_o, 32'd5);
    check_val("t1_alu_op", 32'(bus.alu_op_o), 32'd0);
    check_val("t1_alu_src", 32'(bus.alu_src_o), 32'd1);
    check_val("t1_reg_write", 32'(bus.reg_write_o), 32'd1);
    check_val("t1_illegal", 32'(bus.illegal_o), 32'd0);

    // ADD x3,x2,x2 with same-cycle write-back x2=DEADBEEF
    drive(32'h002101B3, 1, 0, 0, 1, 5'd2, 32'hDEADBEEF);
    tick();
    check_val("t2_rs1_data", bus.rs1_data_o, 32'hDEADBEEF);
    check_val("t2_rs2_data", bus.rs2_data_o, 32'hDEADBEEF);
    check_val("t2_alu_op", 32'(bus.alu_op_o), 32'd0);
    check_val("t2_alu_src", 32'(bus.alu_src_o), 32'd0);

    // write to x0 during a read of x0, then read it again
    drive(32'h000001B3, 1, 0, 0, 1, 5'd0, 32'h00001234);
    tick();
    check_val("t3_rs1_data_wr", bus.rs1_data_o, 32'h0);
    drive(32'h000001B3, 1, 0, 0, 0, 5'd0, 32'h0);
    tick();
    check_val("t3_rs1_data", bus.rs1_data_o, 32'h0);
    check_val("t3_rs2_data", bus.rs2_data_o, 32'h0);

    // BEQ x0,x0,-4
    drive(32'hFE000EE3, 1, 0, 0, 0, 5'd0, 32'h0);
    tick();
    check_val("t4_imm", bus.imm_o, 32'hFFFFFFFC);
    check_val("t4_branch", 32'(bus.branch_o), 32'd1);
    check_val("t4_alu_op", 32'(bus.alu_op_o), 32'd1);
    check_val("t4_reg_write", 32'(bus.reg_write_o), 32'd0);

    // ADD x3,x2,x4 then stall three cycles; write-back x2=7 on the last
    drive(32'h004101B3, 1, 0, 0, 0, 5'd0, 32'h0);
    tick();
    check_val("t5_rs1_data", bus.rs1_data_o, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1, 1, 0, (i == 2), 5'd2, 32'd7);
      tick();
      check_val("t5_stall_rd", 32'(bus.rd_o), 32'd3);
      check_val("t5_stall_valid", 32'(bus.valid_o), 32'd1);
      check_val("t5_stall_rs1_data", bus.rs1_data_o, (i == 2) ? 32'd7 : 32'hDEADBEEF);
      check_val("t5_stall_rs2_data", bus.rs2_data_o, 32'h0);
    end
    drive(32'h00500093, 1, 1, 1, 0, 5'd0, 32'h0);
    tick();
    check_val("t5_flush_valid", 32'(bus.valid_o), 32'd0);
    check_val("t5_flush_reg_write", 32'(bus.reg_write_o), 32'd0);

    // illegal opcode, then asynchronous reset mid-stream
    drive(32'h0000007F, 1, 0, 0, 0, 5'd0, 32'h0);
    tick();
    check_val("t6_illegal", 32'(bus.illegal_o), 32'd1);
    check_val("t6_reg_write", 32'(bus.reg_write_o), 32'd0);
    check_val("t6_jump", 32'(bus.jump_o), 32'd0);
    drive(32'h00500093, 1, 0, 0, 0, 5'd0, 32'h0);
    tick();
    do_reset();
    check_val("t6_rst_alu_op", 32'(bus.alu_op_o), 32'd0);
    drive(32'h004101B3, 1, 0, 0, 0, 5'd0, 32'h0);
    tick();
    check_val("t6_rf_cleared", bus.rs1_data_o, 32'h0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      drive(rand_instr(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 4)), $urandom);
      if (c == 700 || c == 1100) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

- Second pipeline stage of the RV32I core.
- Consumes the registered instruction word from the fetch stage and decodes it into control signals and an immediate.
- Reads two operands from an internal 32×32 register file that has a write-back bypass.
- Presents everything to the execute stage through a stallable, flushable pipeline register.

## Interface

**Parameters**
- XLEN, 32, datapath width
- NREG, 32, register count (x0 hardwired to zero)

**Ports**
- clk1  input  1  stage clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- instr_i  input  32  instruction word from fetch
- instr_valid_i  input  1  instr_i holds a real instruction
- stall_i  input  1  downstream hazard: hold the pipeline register
- flush_i  input  1  kill the instruction being loaded (branch/jump redirect)
- wb_en_i  input  1  register-file write enable from write-back
- wb_rd_i  input  5  write-back destination
- wb_data_i  input  XLEN  write-back data
- valid_o  output  1  outputs describe a live instruction
- rs1_o, rs2_o, rd_o  output  5 each  register indices
- rs1_data_o, rs2_data_o  output  XLEN each  operand values
- imm_o  output  XLEN  sign-extended immediate
- alu_op_o  output  4  ALU operation code
- alu_src_o  output  1  1 = imm_o is operand B
- reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o  output  1 each  control flags
- illegal_o  output  1  unsupported opcode

## Operation

**Opcodes decoded**
- R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Any other opcode: illegal_o=1; reg_write, mem_read, mem_write, branch and jump all 0.

**Immediates**
- I: sext(instr[31:20])
- S: sext({instr[31:25], instr[11:7]})
- B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
- U: {instr[31:12], 12'b0}
- J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
- R-type: 0

**alu_op**
- Codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- SUB only for R-type with funct7[5]=1.
- SRA when funct3=101 and funct7[5]=1 (R and I forms).
- BRANCH → SUB; LUI → PASSB; LOAD, STORE, JAL, JALR, AUIPC → ADD.

**Register file**
- Synchronous write when wb_en_i=1 and wb_rd_i≠0.
- Combinational read.
- Bypass: if wb_en_i=1, wb_rd_i=rsN and rsN≠0, the read returns wb_data_i.
- x0 always reads 0.

**Pipeline register, priority flush > stall > load**
- flush_i: valid_o←0 and all control flags←0.
- stall_i: all outputs hold, except rs1_data_o/rs2_data_o, which reload when a write-back hits rs1_o/rs2_o (index ≠0). Held operands never go stale.
- load: outputs←decode of instr_i; valid_o←instr_valid_i.
- When instr_valid_i=0 the load is a bubble: controls and illegal_o forced to 0.

## Timing

- Latency is 1 cycle: instruction presented at edge N appears on the outputs after edge N+1.
- Write-back and read in the same cycle: the new value reaches rs*_data_o at the next edge, through the bypass.
- Reset (rst=0), asynchronous and immediate, without a clock edge:
  - every output goes to 0, including valid_o, illegal_o and alu_op_o (=ADD);
  - every register-file entry clears to 0.
- Reset mid-stall or mid-flush: reset wins, and the next instruction loads normally after release.
- Simultaneous stall_i and flush_i: treated as flush, valid_o=0 next cycle.
- A write-back to x0 has no effect, and a read of x0 during that write still returns 0.

## Structure

- Shared package rv_decode_pkg holds:
  - opcode constants
  - alu_op codes (also used by execute)
  - immediate-format enum
- Sub-module reg_file (parameterised on XLEN and NREG):
  - async clear, 1 write port, 2 read ports, bypass;
  - reused unchanged by later stages' tests.
- Decode logic stays combinational inside decode_stage, feeding the pipeline register.

## Test plan

1. Release reset, then drive ADDI x1,x0,5 (0x00500093) with valid → next cycle valid_o=1, rd_o=1, imm_o=5, alu_op_o=0, alu_src_o=1, reg_write_o=1, illegal_o=0.
2. Drive wb x2=0xDEADBEEF in the same cycle as ADD x3,x2,x2 (0x002101B3) → rs1_data_o=rs2_data_o=0xDEADBEEF, alu_op_o=0, alu_src_o=0.
3. Drive wb x0=0x1234, then decode ADD x3,x0,x0 → both operand outputs 0.
4. BEQ x0,x0,-4 (0xFE000EE3) → imm_o=0xFFFFFFFC, branch_o=1, alu_op_o=1, reg_write_o=0.
5. Hold stall_i for 3 cycles while instr_i changes → outputs frozen. A write-back of 7 to the held rs1 during the stall → rs1_data_o becomes 7. Raising flush_i together with stall_i → valid_o=0.
6. Illegal word 0x0000007F → illegal_o=1 with all controls 0. Pulling rst low mid-stream → all outputs 0 with no clock edge, and the register file reads back 0.
